// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder.
//   mode_e      : operation select carried on the 'sub' input
//   calc_stages : number of chunk-adder stages for a WIDTH/CHUNK pair
//   cfg_legal   : true when WIDTH/CHUNK form a supported configuration
package pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic logic cfg_legal(input int unsigned width,
                                     input int unsigned chunk);
    return (chunk != 0) && (width >= 8) && (width <= 128) &&
           ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_add_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
//   i_a, i_b : CHUNK-bit operands
//   i_cin    : carry into the slice
//   o_sum    : CHUNK-bit sum
//   o_cout   : carry out of the slice
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits resolved per stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, ovf)
//   sum                 : WIDTH+1-bit result, top bit is carry-out
//                         (subtract: 1 = no borrow)
//   ovf                 : signed overflow of the WIDTH-bit result
// Stage 0 captures a, effective b and carry; stage k adds chunk k-1.
// The whole pipe shifts only when the output slot is free or drained.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if (!cfg_legal(WIDTH, CHUNK)) begin : g_cfg_check
    $error("pipe_adder: illegal WIDTH %0d / CHUNK %0d", WIDTH, CHUNK);
  end

  mode_e                    w_mode;
  logic                     w_adv;
  logic [WIDTH-1:0]         w_b_eff;
  logic                     w_cin_eff;

  // Index k is the stage number; stage 0 is the operand capture stage.
  logic [STAGES:0]          r_v;
  logic [STAGES:0]          r_c;
  logic [STAGES:0]          r_msb_a;
  logic [STAGES:0]          r_msb_b;
  // Low chunks hold finished sum bits, high chunks still hold operand a.
  logic [WIDTH-1:0]         r_acc [STAGES+1];
  logic [WIDTH-1:0]         r_b   [STAGES];

  logic [STAGES-1:0][CHUNK-1:0] w_sum;
  logic [STAGES-1:0]            w_cout;
  logic [WIDTH-1:0]             w_acc_nxt [STAGES];

  assign w_mode   = mode_e'(sub);
  assign w_adv    = !r_v[STAGES] || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_b_eff   = b;
    w_cin_eff = cin;
    if (w_mode == MODE_SUB) begin
      w_b_eff   = ~b;
      w_cin_eff = 1'b1;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    add_chunk #(.CHUNK(CHUNK)) u_add (
      .i_a    (r_acc[k][k*CHUNK +: CHUNK]),
      .i_b    (r_b[k][k*CHUNK +: CHUNK]),
      .i_cin  (r_c[k]),
      .o_sum  (w_sum[k]),
      .o_cout (w_cout[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_acc_nxt[k] = r_acc[k];
      w_acc_nxt[k][k*CHUNK +: CHUNK] = w_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_c     <= '0;
      r_msb_a <= '0;
      r_msb_b <= '0;
      for (int unsigned k = 0; k <= STAGES; k++) r_acc[k] <= '0;
      for (int unsigned k = 0; k < STAGES; k++)  r_b[k]   <= '0;
    end else if (w_adv) begin
      r_v[0]     <= in_valid;
      r_acc[0]   <= a;
      r_b[0]     <= w_b_eff;
      r_c[0]     <= w_cin_eff;
      r_msb_a[0] <= a[WIDTH-1];
      r_msb_b[0] <= w_b_eff[WIDTH-1];
      for (int unsigned k = 1; k <= STAGES; k++) begin
        r_v[k]     <= r_v[k-1];
        r_c[k]     <= w_cout[k-1];
        r_msb_a[k] <= r_msb_a[k-1];
        r_msb_b[k] <= r_msb_b[k-1];
        r_acc[k]   <= w_acc_nxt[k-1];
      end
      for (int unsigned k = 1; k < STAGES; k++) r_b[k] <= r_b[k-1];
    end
  end

  assign out_valid = r_v[STAGES];
  assign sum       = {r_c[STAGES], r_acc[STAGES]};
  assign ovf       = (r_msb_a[STAGES] == r_msb_b[STAGES]) &&
                     (r_acc[STAGES][WIDTH-1] != r_msb_a[STAGES]);

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  localparam int unsigned W   = 32;
  localparam int unsigned C   = 8;
  localparam int          LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    sum;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vcin;
    logic        vsub;
    logic [32:0] es;
    logic        eo;
  } vec_t;

  vec_t dvec [9] = '{
    '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1},
    '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 33'h0_FFFF_FFFE, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 1'b0},
    '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 33'h1_0000_0002, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 33'h1_7FFF_FFFF, 1'b1},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1},
    '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 33'h1_0000_0000, 1'b0}
  };

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== 33'h0) begin errors++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a = dvec[i].va; b = dvec[i].vb; cin = dvec[i].vcin; sub = dvec[i].vsub;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble mode/carry so the in-flight beat must use its own sampled copies.
      sub = ~dvec[i].vsub; cin = ~dvec[i].vcin; a = ~dvec[i].va; b = ~dvec[i].vb;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
      checks++;
      if (sum !== dvec[i].es) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, sum, dvec[i].es); end
      checks++;
      if (ovf !== dvec[i].eo) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, dvec[i].eo); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [32:0] ex [8];
    int nin = 0, nout = 0, cyc = 0, hold = -1;
    logic acc;
    bit dup = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'h1000_0000 * i + 32'h00F0_00F0 + i;
      vb[i] = 32'h0000_FF10 + 3 * i;
      ex[i] = {1'b0, va[i]} + {1'b0, vb[i]};
    end
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    while (nout < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1 && hold < 0) hold = 0;
      out_ready = !(hold >= 0 && hold < 6);
      #1;
      if (hold >= 0 && hold < 6) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d got %b want 0", hold, in_ready); end
        checks++;
        if (sum !== ex[0]) begin errors++; $display("FAIL b2b_stall_sum c%0d got %h want %h", hold, sum, ex[0]); end
        hold++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sum !== ex[nout]) begin errors++; $display("FAIL b2b_result%0d got %h want %h", nout, sum, ex[nout]); end
        nout++;
      end
      if (nin < 8) begin
        in_valid = 1'b1; a = va[nin]; b = vb[nin];
        acc = in_ready;
      end else begin
        in_valid = 1'b0; acc = 1'b0;
      end
      @(posedge clk);
      if (acc) nin++;
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", nout); end
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) dup = 1;
    end
    checks++;
    if (dup) begin errors++; $display("FAIL b2b_extra_result got out_valid 1 want 0"); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    bit stale = 0;
    out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(i + 1); b = 32'h2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_fill got out_valid %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    checks++;
    if (sum !== 33'h0) begin errors++; $display("FAIL rst_async_sum got %h want 0", sum); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    a = 32'h0000_1234; b = 32'h0000_1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL rst_first_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (sum !== 33'h0_0000_2345) begin errors++; $display("FAIL rst_first_sum got %h want 000002345", sum); end
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL rst_stale got out_valid 1 want 0"); end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [32:0] qs [$];
    logic        qo [$];
    logic [31:0] low;
    logic [32:0] es;
    logic        eo, acc;
    int nin = 0, nout = 0, cyc = 0;
    while (nout < N && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (qs.size() == 0) begin
          errors++; $display("FAIL rnd_spurious got %h want no result", sum);
        end else begin
          if (sum !== qs[0] || ovf !== qo[0]) begin
            errors++;
            $display("FAIL rnd_beat%0d got %h/%b want %h/%b", nout, sum, ovf, qs[0], qo[0]);
          end
          void'(qs.pop_front());
          void'(qo.pop_front());
        end
        nout++;
      end
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (nin < N && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        acc = in_ready;
      end else begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      if (acc) begin
        if (sub) begin
          low = a - b;
          es  = {(a >= b), low};
          eo  = (a[31] != b[31]) && (low[31] != a[31]);
        end else begin
          es  = {1'b0, a} + {1'b0, b} + {32'h0, cin};
          low = es[31:0];
          eo  = (a[31] == b[31]) && (low[31] != a[31]);
        end
        qs.push_back(es);
        qo.push_back(eo);
        nin++;
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (nout != N) begin errors++; $display("FAIL rnd_count got %0d want %0d", nout, N); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 8..128.
REQ-002 Parameter CHUNK, default 8, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  pipeline can accept a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only in add mode.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH+1  result; bit WIDTH = carry-out (subtract: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the WIDTH-bit result.

Function
REQ-015 Beat accepted on rising edge where in_valid && in_ready.
REQ-016 Add mode: sum = a + b + cin, full WIDTH+1 bits.
REQ-017 Subtract mode: sum = a + ~b + 1 (cin ignored); sum[WIDTH] = 1 when a >= b unsigned.
REQ-018 ovf = 1 when operand MSBs (a, effective b) are equal and sum[WIDTH-1] differs from them.
REQ-019 Pipeline has STAGES+1 register stages: stage 0 registers a, effective b, carry-in; stage k (1..STAGES) adds chunk k-1 with carry from stage k-1; upper chunks are carried forward unmodified, lower results forward as completed.
REQ-020 Latency: accepted beat appears at out_valid exactly STAGES+1 cycles later with no stall.
REQ-021 Each stage holds a valid bit; bubbles propagate as invalid stages; throughput one beat per cycle.
REQ-022 Advance enable adv = !out_valid || out_ready; all stages shift only when adv = 1; otherwise every stage holds.
REQ-023 in_ready = adv (combinational); in_valid while !in_ready does not change state.
REQ-024 sum, ovf stable while out_valid && !out_ready.
REQ-025 Beats exit in acceptance order; none dropped or duplicated.
REQ-026 sub and cin are sampled with the beat; changes on other beats do not affect it.
REQ-027 Wrap-around: a = b = all-ones, cin = 1 -> sum = {1, all-ones}; no special case.

Reset
REQ-028 On rst_n low, all stage valid bits, out_valid, sum, ovf and stored operands clear to 0 immediately.
REQ-029 Reset mid-operation discards all in-flight beats; no result from them is ever presented.
REQ-030 First beat after rst_n deassertion is accepted on the first rising edge with in_valid high.

Structure
REQ-031 Package pipe_adder_pkg holds mode encodings (MODE_ADD = 0, MODE_SUB = 1) and the STAGES derivation function.
REQ-032 One combinational sub-module add_chunk (CHUNK-bit add with cin/cout), instantiated STAGES times via generate.
REQ-033 Illegal WIDTH/CHUNK combination is an elaboration error.

Verification (WIDTH = 32, CHUNK = 8, latency 5)
REQ-034 a = 0x0000_00FF, b = 0x0000_0001, add, cin 0 -> after 5 cycles sum = 0x0_0000_0100, ovf 0.
REQ-035 a = 0xFFFF_FFFF, b = 0x0000_0000, cin 1 -> sum = 0x1_0000_0000 (carry ripples through all 4 stages).
REQ-036 a = 0x7FFF_FFFF, b = 1 add -> sum = 0x0_8000_0000, ovf 1; a = 3, b = 5 sub -> sum = 0x0_FFFF_FFFE, ovf 0.
REQ-037 Back-to-back 8 beats with out_ready held low after first result -> in_ready drops, pipe holds, sum stable; release -> 8 results in order, none lost.
REQ-038 Assert rst_n low with 3 beats in flight -> out_valid 0 same cycle; after release no stale result appears.
REQ-039 Random add/sub, random valid/ready at WIDTH 32/CHUNK 8 and WIDTH 64/CHUNK 16 against a reference model, 10^5 beats.
